// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store sequencer.
//   - funct3 encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - FSM state enum (IDLE/REQ/RESP/DONE)
//   - NUM_LANES: byte lanes per data word
//   - helpers to classify an access as legal and/or misaligned
package lsu_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Stores only come in byte/half/word; loads add the unsigned byte/half forms.
    function automatic logic type_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        else
            return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    // size is funct3[1:0]: 01 = halfword, 10 = word. Byte accesses never misalign.
    function automatic logic type_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store sequencer.
//   ls_type   in  funct3 of the access (bits [1:0] give the size)
//   addr_lo   in  low two bits of the byte address
//   wdata     in  store data (rs2)
//   bus_rdata in  raw word returned by the bus
//   be        out byte enables for the access size and offset
//   wdata_rep out store data replicated across every lane it could land in
//   rdata_ext out load data shifted down and sign/zero extended
// Address bits below the access size are ignored, so a misaligned access
// simply lands on the containing naturally-aligned lanes.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]           ls_type,
    input  logic [1:0]           addr_lo,
    input  logic [DWIDTH-1:0]    wdata,
    input  logic [DWIDTH-1:0]    bus_rdata,
    output logic [NUM_LANES-1:0] be,
    output logic [DWIDTH-1:0]    wdata_rep,
    output logic [DWIDTH-1:0]    rdata_ext
);

    localparam int LANE_W = DWIDTH / NUM_LANES;

    logic [1:0]          size;
    logic [LANE_W-1:0]   ld_byte;
    logic [2*LANE_W-1:0] ld_half;
    logic                sign_ext;

    assign size     = ls_type[1:0];
    assign sign_ext = ~ls_type[2];

    always_comb begin
        case (size)
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    // Each lane picks the source byte it would carry for a byte, half or word store.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign wdata_rep[gi*LANE_W +: LANE_W] =
                (size == 2'b00) ? wdata[LANE_W-1:0] :
                (size == 2'b01) ? wdata[(gi%2)*LANE_W +: LANE_W] :
                                  wdata[gi*LANE_W +: LANE_W];
        end
    endgenerate

    assign ld_byte = bus_rdata[addr_lo*LANE_W +: LANE_W];
    assign ld_half = bus_rdata[addr_lo[1]*2*LANE_W +: 2*LANE_W];

    always_comb begin
        case (size)
            2'b00:   rdata_ext = {{(DWIDTH-LANE_W){ld_byte[LANE_W-1] & sign_ext}}, ld_byte};
            2'b01:   rdata_ext = {{(DWIDTH-2*LANE_W){ld_half[2*LANE_W-1] & sign_ext}}, ld_half};
            default: rdata_ext = bus_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between decode/execute and a handshaked
// data-memory bus. Latches the request, runs one bus transaction, stalls
// the PC meanwhile and returns extended load data in rdata.
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_req/mem_we/ls_type  request from the current instruction
//   addr, wdata             ALU byte address, store data
//   stall, done, err        PC hold, completion pulse, error pulse (with done)
//   rdata                   registered load result, held until the next load
//   bus_req/we/addr/be/wdata  request channel, valid while bus_req=1
//   bus_gnt, bus_rvalid, bus_rdata  grant and read-response channel
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into an immediate error instead of a lane-truncated access.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        ls_type,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [DWIDTH-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [AWIDTH-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DWIDTH-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DWIDTH-1:0] bus_rdata
);

    localparam int          CW      = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    lsu_state_e        state_reg, state_next;
    logic              err_reg, err_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [DWIDTH-1:0] rdata_reg, rdata_next;
    logic              we_reg;
    logic [2:0]        type_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [DWIDTH-1:0] wdata_reg;
    logic              latch_en;
    logic              trap;
    logic [3:0]        be_calc;
    logic [DWIDTH-1:0] wdata_calc;
    logic [DWIDTH-1:0] rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = type_misaligned(ls_type[1:0], addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_align #(.DWIDTH(DWIDTH)) u_align (
        .ls_type   (type_reg),
        .addr_lo   (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .bus_rdata (bus_rdata),
        .be        (be_calc),
        .wdata_rep (wdata_calc),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            we_reg    <= 1'b0;
            type_reg  <= 3'b000;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            if (latch_en) begin
                we_reg    <= mem_we;
                type_reg  <= ls_type;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
        end
    end

    // Timeout takes priority over a load grant in the last allowed cycle so
    // the REQ+RESP budget is a hard bound; a store grant there still completes.
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        latch_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    latch_en = 1'b1;
                    cnt_next = '0;
                    if (!type_legal(mem_we, ls_type) || trap) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                        if (!mem_we) rdata_next = '0;
                    end else begin
                        state_next = REQ;
                        err_next   = 1'b0;
                    end
                end
            end
            REQ: begin
                cnt_next = cnt_reg + 1'b1;
                if (bus_gnt && we_reg) begin
                    state_next = DONE;
                    err_next   = 1'b0;
                end else if (cnt_reg == TO_LAST) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                    if (!we_reg) rdata_next = '0;
                end else if (bus_gnt) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                cnt_next = cnt_reg + 1'b1;
                if (bus_rvalid) begin
                    state_next = DONE;
                    err_next   = 1'b0;
                    rdata_next = rdata_ext;
                end else if (cnt_reg == TO_LAST) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end
            end
            DONE: begin
                state_next = IDLE;
                err_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    // rst_n gates stall so it drops the moment reset asserts, even with mem_req high.
    assign stall     = rst_n && (((state_reg == IDLE) && mem_req) ||
                                 (state_reg == REQ) || (state_reg == RESP));
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == DONE) && err_reg;
    assign rdata     = rdata_reg;
    assign bus_req   = (state_reg == REQ);
    assign bus_we    = bus_req ? we_reg : 1'b0;
    assign bus_addr  = bus_req ? {addr_reg[AWIDTH-1:2], 2'b00} : '0;
    assign bus_be    = bus_req ? be_calc : 4'b0000;
    assign bus_wdata = bus_req ? wdata_calc : '0;

endmodule
